// File: rtl/pclk_freq_monitor.sv
// Frequency qualifier for PCLK, measured from Ref_Clk by counting synchronised Mon_Toggle edges
// over a fixed window and requiring consecutive good windows before Locked asserts.
module pclk_freq_monitor #(
    parameter int unsigned WINDOW     = 1024,
    parameter int unsigned TOG_DIV    = 64,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic       Ref_Clk,
    input  logic       Rst_n,
    input  logic       Enable,
    input  logic [5:0] DataBusWidth,
    input  logic       Mon_Toggle,
    output logic       Locked,
    output logic       Window_Done,
    output logic [7:0] Count_Value,
    output logic       Freq_Err
);

    localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    // Expected edges per window: 5 GHz / ratio * WINDOW * 10 ns / TOG_DIV, ratio 10/20/40
    localparam int unsigned Exp8  = (50 * WINDOW) / (10 * TOG_DIV);
    localparam int unsigned Exp16 = (50 * WINDOW) / (20 * TOG_DIV);
    localparam int unsigned Exp32 = (50 * WINDOW) / (40 * TOG_DIV);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StHold} state_e;

    state_e          state_q;
    logic            sync1_q, sync2_q, sync3_q;
    logic            tog_edge;
    logic [WinW-1:0] win_cnt_q;
    logic [7:0]      edge_cnt_q;
    logic [7:0]      good_cnt_q;
    logic [7:0]      bad_cnt_q;
    logic [5:0]      dbw_q;
    logic            win_end;
    logic            dbw_change;
    logic [7:0]      exp_cnt;
    logic [7:0]      cnt_sat;
    logic [7:0]      cnt_diff;
    logic            win_bad;

    assign tog_edge   = sync2_q ^ sync3_q;
    assign win_end    = (win_cnt_q == WinW'(WINDOW - 1));
    // The registered copy tracks freely in IDLE, so only a change while measuring restarts lock
    assign dbw_change = (state_q != StIdle) && (DataBusWidth != dbw_q);
    assign cnt_sat    = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + {7'd0, tog_edge};
    assign cnt_diff   = (cnt_sat >= exp_cnt) ? cnt_sat - exp_cnt : exp_cnt - cnt_sat;
    assign win_bad    = (cnt_diff > 8'(TOL));

    always_comb begin
        exp_cnt = 8'(Exp8);
        case (dbw_q)
            6'd16:   exp_cnt = 8'(Exp16);
            6'd32:   exp_cnt = 8'(Exp32);
            default: exp_cnt = 8'(Exp8);
        endcase
    end

    always_ff @(posedge Ref_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= Mon_Toggle;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge Ref_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            win_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            dbw_q       <= '0;
            Locked      <= 1'b0;
            Window_Done <= 1'b0;
            Count_Value <= '0;
            Freq_Err    <= 1'b0;
        end else begin
            dbw_q       <= DataBusWidth;
            Window_Done <= 1'b0;
            if (!Enable) begin
                state_q    <= StIdle;
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                Locked     <= 1'b0;
            end else if (dbw_change) begin
                state_q    <= StAcquire;
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                Locked     <= 1'b0;
            end else begin
                win_cnt_q <= win_end ? '0 : win_cnt_q + 1'b1;
                if (win_end) begin
                    edge_cnt_q  <= '0;
                    Window_Done <= 1'b1;
                    Count_Value <= cnt_sat;
                    Freq_Err    <= win_bad;
                    case (state_q)
                        StIdle: begin
                            // First window is partial; it is published but never scored
                            state_q    <= StAcquire;
                            good_cnt_q <= '0;
                            bad_cnt_q  <= '0;
                        end
                        StAcquire: begin
                            if (win_bad) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q + 8'd1 == 8'(LOCK_CNT)) begin
                                state_q    <= StLocked;
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                                Locked     <= 1'b1;
                            end else begin
                                good_cnt_q <= good_cnt_q + 8'd1;
                            end
                        end
                        StLocked: begin
                            if (win_bad) begin
                                state_q   <= StHold;
                                bad_cnt_q <= 8'd1;
                            end
                        end
                        StHold: begin
                            if (!win_bad) begin
                                state_q   <= StLocked;
                                bad_cnt_q <= '0;
                            end else if (bad_cnt_q + 8'd1 == 8'(UNLOCK_CNT)) begin
                                state_q    <= StAcquire;
                                good_cnt_q <= '0;
                                bad_cnt_q  <= '0;
                                Locked     <= 1'b0;
                            end else begin
                                bad_cnt_q <= bad_cnt_q + 8'd1;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end else if (tog_edge && (edge_cnt_q != 8'hFF)) begin
                    edge_cnt_q <= edge_cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pclk_freq_monitor.sv
// Randomised bench for pclk_freq_monitor: per-window toggle counts are checked against a
// window-level model of the count, tolerance and lock/unlock hysteresis rules.
module tb_pclk_freq_monitor;

    localparam int WINDOW     = 1024;
    localparam int TOL        = 2;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [5:0] dbw;
    logic       mon;
    logic       locked;
    logic       wd;
    logic [7:0] cnt;
    logic       err;

    always #5 clk = ~clk;

    pclk_freq_monitor #(
        .WINDOW    (WINDOW),
        .TOG_DIV   (64),
        .TOL       (TOL),
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .Ref_Clk     (clk),
        .Rst_n       (rst_n),
        .Enable      (enable),
        .DataBusWidth(dbw),
        .Mon_Toggle  (mon),
        .Locked      (locked),
        .Window_Done (wd),
        .Count_Value (cnt),
        .Freq_Err    (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: lock status, consecutive good/bad run lengths, last published result
    int m_locked, m_good, m_bad, m_cnt, m_err;
    bit m_scored;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_for(input logic [5:0] w);
        case (w)
            6'd16:   return 40;
            6'd32:   return 20;
            default: return 80;
        endcase
    endfunction

    function automatic void model_reset(input bit scored);
        m_locked = 0;
        m_good   = 0;
        m_bad    = 0;
        m_scored = scored;
    endfunction

    function automatic void model_window(input int toggles);
        int diff;
        m_cnt = (toggles > 255) ? 255 : toggles;
        diff  = m_cnt - exp_for(dbw);
        if (diff < 0) diff = -diff;
        m_err = (diff > TOL) ? 1 : 0;
        if (!m_scored) begin
            m_scored = 1;
        end else if (m_locked == 0) begin
            m_good = m_err ? 0 : m_good + 1;
            if (m_good == LOCK_CNT) begin
                m_locked = 1;
                m_bad    = 0;
            end
        end else begin
            m_bad = m_err ? m_bad + 1 : 0;
            if (m_bad == UNLOCK_CNT) begin
                m_locked = 0;
                m_good   = 0;
            end
        end
    endfunction

    // One full window; toggles are kept clear of the boundaries so each lands in this window
    task automatic run_window(input int n, input bit every, input string tag);
        bit sched [WINDOW];
        bit early = 0;
        int sp;
        for (int j = 0; j < WINDOW; j++) sched[j] = 0;
        if (every) begin
            for (int j = 8; j <= 1000; j++) sched[j] = 1;
        end else if (n > 0) begin
            sp = 990 / n;
            for (int i = 0; i < n; i++) sched[8 + i * sp + int'($urandom_range(sp - 1, 0))] = 1;
        end
        for (int j = 0; j < WINDOW; j++) begin
            if (sched[j]) mon = ~mon;
            @(posedge clk);
            #1;
            if (j < WINDOW - 1 && wd) early = 1;
        end
        model_window(every ? 1000 : n);
        check_val({tag, " window_done"}, wd, 1);
        check_val({tag, " early_done"}, early, 0);
        check_val({tag, " count"}, cnt, m_cnt);
        check_val({tag, " freq_err"}, err, m_err);
        check_val({tag, " locked"}, locked, m_locked);
    endtask

    task automatic lock_up(input string tag);
        for (int k = 0; k < 8 && m_locked == 0; k++) run_window(exp_for(dbw), 0, tag);
        check_val({tag, " lock_up"}, locked, 1);
    endtask

    task automatic change_dbw(input logic [5:0] w, input int pre, input string tag);
        repeat (pre) @(posedge clk);
        #1;
        dbw = w;
        @(posedge clk);
        #1;
        model_reset(1);
        check_val({tag, " dbw_chg locked"}, locked, 0);
        check_val({tag, " dbw_chg done"}, wd, 0);
    endtask

    initial begin
        logic [5:0] widths [4];
        int         idx;
        widths[0] = 6'd8;
        widths[1] = 6'd16;
        widths[2] = 6'd32;
        widths[3] = 6'd4;
        rst_n  = 1'b0;
        enable = 1'b0;
        dbw    = 6'd8;
        mon    = 1'b0;
        model_reset(0);
        m_cnt = 0;
        m_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset locked", locked, 0);
        check_val("reset done", wd, 0);
        check_val("reset count", cnt, 0);
        check_val("reset freq_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal 80 edges/window: first window unscored, lock at the fifth result
        enable = 1'b1;
        for (int w = 0; w < 5; w++) run_window(80, 0, "t1");
        for (int w = 0; w < 6; w++) run_window(76 + int'($urandom_range(8, 0)), 0, "rnd8");

        // Two slow windows unlock after the second
        change_dbw(6'd16, 0, "t2");
        lock_up("t2");
        run_window(30, 0, "t2 bad1");
        run_window(30, 0, "t2 bad2");

        // Tolerance boundary: 43 bad, 42 good; a single bad window never unlocks
        lock_up("t3");
        run_window(43, 0, "t3 43");
        run_window(42, 0, "t3 42");
        run_window(40, 0, "t3 40a");
        run_window(40, 0, "t3 40b");

        // Bus width change mid-window drops lock and restarts the window
        change_dbw(6'd8, 0, "t4a");
        lock_up("t4a");
        change_dbw(6'd32, 500, "t4b");
        for (int w = 0; w < 4; w++) run_window(20, 0, "t4 relock");

        // Saturation
        run_window(0, 1, "t5 sat1");
        run_window(0, 1, "t5 sat2");

        // Enable drop: lock clears, last result held
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_val("en_drop locked", locked, 0);
        check_val("en_drop done", wd, 0);
        check_val("en_drop count", cnt, m_cnt);
        check_val("en_drop freq_err", err, m_err);
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b1;
        model_reset(0);
        lock_up("en_relock");

        // Asynchronous reset mid-window
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        mon   = 1'b0;
        #1;
        check_val("t6 locked", locked, 0);
        check_val("t6 done", wd, 0);
        check_val("t6 count", cnt, 0);
        check_val("t6 freq_err", err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(0);
        run_window(exp_for(dbw), 0, "t6 first");

        // Random mix of widths and counts
        for (int w = 0; w < 8; w++) begin
            if ($urandom_range(3, 0) == 0) begin
                idx = int'($urandom_range(3, 0));
                if (widths[idx] == dbw) idx = (idx + 1) % 4;
                change_dbw(widths[idx], 0, "rnd chg");
            end
            run_window(exp_for(dbw) - 5 + int'($urandom_range(10, 0)), 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
